// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/clear stopwatch FSM gating a DIV prescaler and a 4-digit BCD count; optional lap hold under LAP_HOLD_EN
module stopwatch_ctrl #(
  parameter int DIV  = 10,
  parameter int WRAP = 1
) (
  input  logic        cin,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
`ifdef LAP_HOLD_EN
  input  logic        lap,
`endif
  output logic [15:0] digits,
  output logic        tick,
  output logic        running,
  output logic        done
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   cnt_q, cnt_d, cnt_inc;
  logic          tick_q, tick_d;
  logic          carry;
  // ripple BCD +1: a digit at 9 wraps to 0 and passes the carry upward
  always_comb begin
    cnt_inc = cnt_q;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        cnt_inc[4*i +: 4] = (cnt_q[4*i +: 4] == 4'd9) ? 4'd0 : cnt_q[4*i +: 4] + 4'd1;
        carry = (cnt_q[4*i +: 4] == 4'd9);
      end
    end
  end
  // next state: clear beats stop beats start; stop in RUN freezes presc where it is
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d = cnt_q;
    tick_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      presc_d = '0;
      cnt_d = '0;
    end else if (state_q == IDLE) begin
      if (!stop && start) begin
        state_d = RUN;
        presc_d = '0;
      end
    end else if (state_q == PAUSE) begin
      if (!stop && start) state_d = RUN;
    end else if (state_q == RUN) begin
      if (stop) state_d = PAUSE;
      else if (presc_q == PMAX) begin
        presc_d = '0;
        tick_d = 1'b1;
        if (cnt_q == 16'h9999 && WRAP == 0) state_d = DONE;
        else cnt_d = cnt_inc;
      end else presc_d = presc_q + 1'b1;
    end
  end
  // state, prescaler, count and tick registers
  always_ff @(posedge cin) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q <= cnt_d;
      tick_q <= tick_d;
    end
  end
  assign tick = tick_q;
  assign running = (state_q == RUN);
  assign done = (state_q == DONE);
`ifdef LAP_HOLD_EN
  logic        hold_q;
  logic [15:0] lap_q;
  // lap toggles a frozen snapshot of the count while RUN/PAUSE; clear drops it
  always_ff @(posedge cin) begin
    if (reset || clear) begin
      hold_q <= 1'b0;
      lap_q <= '0;
    end else if (lap && (state_q == RUN || state_q == PAUSE)) begin
      hold_q <= !hold_q;
      if (!hold_q) lap_q <= cnt_q;
    end
  end
  assign digits = hold_q ? lap_q : cnt_q;
`else
  assign digits = cnt_q;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: three stopwatch configs on shared stimulus, checked against a decimal-count model via a scoreboard queue
module tb_stopwatch_ctrl;
  logic cin = 1'b0;
  logic reset = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [15:0] dig [3];
  logic tk [3], rn [3], dn [3];
  int n_tests = 0, n_fail = 0, ncyc = 0;
  int m_st [3], m_p [3], m_n [3], m_hv [3];
  bit m_tk [3], m_hf [3];
  int dv [3] = '{4, 1, 1};
  int wr [3] = '{1, 1, 0};
  logic [31:0] sb [$];

  always #5 cin = ~cin;

  stopwatch_ctrl #(.DIV(4), .WRAP(1)) u_a (.cin(cin), .reset(reset), .start(start), .stop(stop), .clear(clear),
`ifdef LAP_HOLD_EN
    .lap(lap),
`endif
    .digits(dig[0]), .tick(tk[0]), .running(rn[0]), .done(dn[0]));
  stopwatch_ctrl #(.DIV(1), .WRAP(1)) u_b (.cin(cin), .reset(reset), .start(start), .stop(stop), .clear(clear),
`ifdef LAP_HOLD_EN
    .lap(lap),
`endif
    .digits(dig[1]), .tick(tk[1]), .running(rn[1]), .done(dn[1]));
  stopwatch_ctrl #(.DIV(1), .WRAP(0)) u_c (.cin(cin), .reset(reset), .start(start), .stop(stop), .clear(clear),
`ifdef LAP_HOLD_EN
    .lap(lap),
`endif
    .digits(dig[2]), .tick(tk[2]), .running(rn[2]), .done(dn[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] exp_of(input int i);
    return {13'd0, m_hf[i] ? bcd(m_hv[i]) : bcd(m_n[i]), m_tk[i], m_st[i] == 1, m_st[i] == 3};
  endfunction

  function automatic logic [31:0] obs(input int i);
    return {13'd0, dig[i], tk[i], rn[i], dn[i]};
  endfunction

  // states: 0 idle, 1 run, 2 pause, 3 done
  task automatic model_step(input int i, input bit s, input bit t, input bit c, input bit r, input bit l);
    if (r || c) begin
      m_st[i] = 0; m_p[i] = 0; m_n[i] = 0; m_tk[i] = 0; m_hf[i] = 0; m_hv[i] = 0;
    end else begin
      if (l && (m_st[i] == 1 || m_st[i] == 2)) begin
        if (m_hf[i]) m_hf[i] = 0;
        else begin m_hf[i] = 1; m_hv[i] = m_n[i]; end
      end
      m_tk[i] = 0;
      case (m_st[i])
        0: if (!t && s) begin m_st[i] = 1; m_p[i] = 0; end
        1: if (t) m_st[i] = 2;
           else if (m_p[i] == dv[i] - 1) begin
             m_p[i] = 0; m_tk[i] = 1;
             if (m_n[i] < 9999) m_n[i]++;
             else if (wr[i] != 0) m_n[i] = 0;
             else m_st[i] = 3;
           end else m_p[i]++;
        2: if (!t && s) m_st[i] = 1;
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input bit s, input bit t, input bit c, input bit r, input bit l);
    @(negedge cin);
    start = s; stop = t; clear = c; reset = r; lap = l;
    for (int i = 0; i < 3; i++) begin
      model_step(i, s, t, c, r, l);
      sb.push_back(exp_of(i));
    end
    @(posedge cin);
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("cyc%0d_u%0d", ncyc, i), obs(i), sb.pop_front());
    ncyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("reset_a", obs(0), 32'h0);
    cyc(1, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      idle(1);
      if (k % 4 == 0) chk($sformatf("run_a_%0d", k), obs(0), {13'd0, bcd(k / 4), 3'b110});
    end
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle(6);
    cyc(0, 1, 0, 0, 0);
    idle(20);
    chk("pause_a", obs(0), {13'd0, 16'h0001, 3'b000});
    cyc(1, 0, 0, 0, 0);
    idle(1);
    chk("resume1_a", 32'(tk[0]), 32'h0);
    idle(1);
    chk("resume2_a", obs(0), {13'd0, 16'h0002, 3'b110});
    cyc(1, 1, 1, 0, 0);
    chk("ssc_a", obs(0), 32'h0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("ss_pause_a", 32'(rn[0]), 32'h0);
    cyc(1, 0, 0, 0, 0);
    idle(3);
    cyc(0, 0, 0, 1, 0);
    chk("midreset_a", obs(0), 32'h0);
    chk("midreset_b", obs(1), 32'h0);
    cyc(1, 0, 0, 0, 0);
    for (int k = 1; k <= 9999; k++) begin
      idle(1);
      if (k == 9 || k == 10 || k == 999 || k == 1000) chk($sformatf("carry_b_%0d", k), 32'(dig[1]), 32'(bcd(k)));
    end
    chk("top_c", obs(2), {13'd0, 16'h9999, 3'b110});
    idle(1);
    chk("wrap_b", obs(1), {13'd0, 16'h0000, 3'b110});
    chk("sat_c", obs(2), {13'd0, 16'h9999, 3'b101});
    cyc(1, 0, 0, 0, 0);
    chk("done_ign_c", obs(2), {13'd0, 16'h9999, 3'b001});
    cyc(0, 0, 1, 0, 0);
    chk("done_clr_c", obs(2), 32'h0);
`ifdef LAP_HOLD_EN
    cyc(1, 0, 0, 0, 0);
    idle(12);
    cyc(0, 0, 0, 0, 1);
    chk("lap1_a", 32'(dig[0]), 32'h0003);
    idle(15);
    chk("lap_hold_a", {15'd0, dig[0], tk[0]}, {15'd0, 16'h0003, 1'b1});
    cyc(0, 0, 0, 0, 1);
    chk("lap2_a", 32'(dig[0]), 32'h0007);
`endif
    for (int k = 0; k < 600; k++) begin
      bit l;
      l = 1'b0;
`ifdef LAP_HOLD_EN
      l = ($urandom_range(0, 15) == 0);
`endif
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 40) == 0,
          $urandom_range(0, 99) == 0, l);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
